// File: rtl/async_fifo_wr_arbiter.sv
// async_fifo_wr_arbiter: round-robin, burst-granular arbiter sharing one async FIFO write port.
// Define ASYNC_FIFO_ARB_SRCID_EN to prepend the granted source index to every written word.
module async_fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST = 16,
  localparam int IDW = $clog2(NUM_REQ),
`ifdef ASYNC_FIFO_ARB_SRCID_EN
  localparam int FW = DATA_WIDTH + IDW
`else
  localparam int FW = DATA_WIDTH
`endif
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_walmost_full_i,
  input  logic                          fifo_wfull_i,
  output logic                          fifo_wr_en_o,
  output logic [FW-1:0]                 fifo_wdata_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          split_o
);
  localparam int BW = $clog2(MAX_BURST);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nx;
  logic [NUM_REQ-1:0] grant_nx;
  logic [IDW-1:0] rr_ptr, rr_ptr_nx, gidx, winner;
  logic [BW-1:0] beat_cnt, beat_cnt_nx;
  logic [DATA_WIDTH-1:0] gdata;
  logic split_nx, xfer, release_now;
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_o[i]) gidx = IDW'(i);
  end
  // Scan downward so the nearest valid index after rr_ptr is the last one assigned.
  always_comb begin
    winner = rr_ptr;
    for (int i = NUM_REQ; i >= 1; i--)
      if (req_valid_i[(int'(rr_ptr) + i) % NUM_REQ]) winner = IDW'((int'(rr_ptr) + i) % NUM_REQ);
  end
  assign gdata = req_data_i[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
  assign req_ready_o = (reset_n_i && state == BURST && !fifo_wfull_i) ? grant_o : '0;
  assign xfer = |(req_ready_o & req_valid_i);
  assign fifo_wr_en_o = xfer;
  assign release_now = xfer && (req_last_i[gidx] || beat_cnt == BW'(MAX_BURST - 1));
`ifdef ASYNC_FIFO_ARB_SRCID_EN
  assign fifo_wdata_o = reset_n_i ? {gidx, gdata} : '0;
`else
  assign fifo_wdata_o = reset_n_i ? gdata : '0;
`endif
  always_comb begin
    state_nx = state;
    grant_nx = grant_o;
    rr_ptr_nx = rr_ptr;
    beat_cnt_nx = beat_cnt;
    split_nx = 1'b0;
    if (state == IDLE) begin
      if (|req_valid_i && !fifo_walmost_full_i) begin
        state_nx = BURST;
        grant_nx = NUM_REQ'(1) << winner;
      end
    end else if (release_now) begin
      state_nx = IDLE;
      grant_nx = '0;
      rr_ptr_nx = gidx;
      beat_cnt_nx = '0;
      split_nx = !req_last_i[gidx];
    end else if (xfer) begin
      beat_cnt_nx = beat_cnt + BW'(1);
    end
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      grant_o <= '0;
      rr_ptr <= IDW'(NUM_REQ - 1);
      beat_cnt <= '0;
      split_o <= 1'b0;
    end else begin
      state <= state_nx;
      grant_o <= grant_nx;
      rr_ptr <= rr_ptr_nx;
      beat_cnt <= beat_cnt_nx;
      split_o <= split_nx;
    end
  end
endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// tb_async_fifo_wr_arbiter: vector table, directed corner sequences and randomized traffic
// checked against an integer-level model of the arbitration rules.
module tb_async_fifo_wr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_WIDTH = 16;
  localparam int MAX_BURST = 16;
  localparam int IDW = 2;
`ifdef ASYNC_FIFO_ARB_SRCID_EN
  localparam int FW = DATA_WIDTH + IDW;
`else
  localparam int FW = DATA_WIDTH;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [NUM_REQ-1:0] req_valid = '0;
  logic [NUM_REQ-1:0] req_last = '0;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data = '0;
  logic [NUM_REQ-1:0] req_ready, grant;
  logic walmost_full = 1'b0;
  logic wfull = 1'b0;
  logic wr_en, split;
  logic [FW-1:0] wdata;
  int n_cmp = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  async_fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .req_valid_i(req_valid), .req_last_i(req_last),
    .req_data_i(req_data), .req_ready_o(req_ready), .fifo_walmost_full_i(walmost_full),
    .fifo_wfull_i(wfull), .fifo_wr_en_o(wr_en), .fifo_wdata_o(wdata), .grant_o(grant),
    .split_o(split)
  );
  // model: owner index (-1 = idle), beats taken in this grant, last released index
  int m_owner = -1;
  int m_cnt = 0;
  int m_rr = NUM_REQ - 1;
  bit m_split = 1'b0;
  int left[NUM_REQ];
  int seq[NUM_REQ];
  logic [NUM_REQ-1:0] xfer_seen = '0;
  int wr_count = 0;
  int split_count = 0;
  int src_log[$];
  typedef struct packed {
    logic [3:0] valid;
    logic [3:0] last;
    logic af;
    logic full;
    logic [3:0] grant;
    logic [3:0] ready;
    logic wen;
  } vec_t;
  vec_t vt[16];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void model_reset();
    m_owner = -1;
    m_cnt = 0;
    m_rr = NUM_REQ - 1;
    m_split = 1'b0;
  endfunction
  function automatic void model_step();
    m_split = 1'b0;
    if (m_owner < 0) begin
      if (|req_valid && !walmost_full)
        for (int i = 1; i <= NUM_REQ; i++)
          if (m_owner < 0 && req_valid[(m_rr + i) % NUM_REQ]) m_owner = (m_rr + i) % NUM_REQ;
      m_cnt = 0;
    end else if (req_valid[m_owner] && !wfull) begin
      m_cnt++;
      if (req_last[m_owner] || m_cnt == MAX_BURST) begin
        m_split = !req_last[m_owner];
        m_rr = m_owner;
        m_owner = -1;
      end
    end
  endfunction
  task automatic sample();
    logic [NUM_REQ-1:0] eg, er;
    logic ew;
    logic [FW-1:0] ed;
    @(negedge clk);
    eg = (m_owner < 0) ? '0 : NUM_REQ'(1) << m_owner;
    er = (m_owner >= 0 && !wfull) ? eg : '0;
    ew = m_owner >= 0 && req_valid[m_owner] && !wfull;
    chk("grant", 64'(grant), 64'(eg));
    chk("ready", 64'(req_ready), 64'(er));
    chk("wr_en", 64'(wr_en), 64'(ew));
    chk("split", 64'(split), 64'(m_split));
    if (ew) begin
`ifdef ASYNC_FIFO_ARB_SRCID_EN
      ed = {IDW'(m_owner), req_data[m_owner*DATA_WIDTH +: DATA_WIDTH]};
`else
      ed = req_data[m_owner*DATA_WIDTH +: DATA_WIDTH];
`endif
      chk("wdata", 64'(wdata), 64'(ed));
    end
    xfer_seen = req_valid & req_ready;
    if (wr_en) begin
      wr_count++;
      src_log.push_back(int'(wdata[DATA_WIDTH-1 -: 4]));
    end
    if (split) split_count++;
  endtask
  task automatic advance();
    if (reset_n) model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic tick();
    sample();
    advance();
  endtask
  // Requesters obey the hold-until-ready rule; data encodes {source, sequence}.
  task automatic drive(input bit rnd);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (xfer_seen[k]) begin
        left[k]--;
        seq[k]++;
      end
      if (rnd && left[k] == 0) left[k] = $urandom_range(20, 1);
      if (!(req_valid[k] && !xfer_seen[k]))
        req_valid[k] = left[k] > 0 && (!rnd || $urandom_range(2, 0) != 0);
      req_last[k] = left[k] == 1;
      req_data[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'((k << 12) | (seq[k] & 'hfff));
    end
    xfer_seen = '0;
  endtask
  task automatic idle_reqs();
    req_valid = '0;
    req_last = '0;
    xfer_seen = '0;
    for (int k = 0; k < NUM_REQ; k++) left[k] = 0;
  endtask
  initial begin
    int wc;
    int exp_src[$];
    for (int k = 0; k < NUM_REQ; k++) begin
      left[k] = 0;
      seq[k] = 0;
      req_data[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'((k << 12) | 'h5a);
    end
    vt[0]  = '{4'hf, 4'hf, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vt[1]  = '{4'hf, 4'hf, 1'b0, 1'b0, 4'h1, 4'h1, 1'b1};
    vt[2]  = '{4'hf, 4'hf, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vt[3]  = '{4'hf, 4'hf, 1'b0, 1'b0, 4'h2, 4'h2, 1'b1};
    vt[4]  = '{4'hf, 4'hf, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vt[5]  = '{4'hf, 4'hf, 1'b0, 1'b0, 4'h4, 4'h4, 1'b1};
    vt[6]  = '{4'hf, 4'hf, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vt[7]  = '{4'hf, 4'hf, 1'b0, 1'b0, 4'h8, 4'h8, 1'b1};
    vt[8]  = '{4'hf, 4'hf, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vt[9]  = '{4'hf, 4'hf, 1'b0, 1'b0, 4'h1, 4'h1, 1'b1};
    vt[10] = '{4'h2, 4'h2, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0};
    vt[11] = '{4'h2, 4'h2, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0};
    vt[12] = '{4'h2, 4'h2, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    vt[13] = '{4'h2, 4'h2, 1'b0, 1'b1, 4'h2, 4'h0, 1'b0};
    vt[14] = '{4'h2, 4'h2, 1'b0, 1'b0, 4'h2, 4'h2, 1'b1};
    vt[15] = '{4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    #1 reset_n = 1'b0;
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_wdata", 64'(wdata), 64'(0));
    chk("rst_split", 64'(split), 64'(0));
    req_valid = '0;
    reset_n = 1'b1;
    model_reset();
    // round-robin order with one idle cycle between bursts, then almost-full gating
    foreach (vt[i]) begin
      req_valid = vt[i].valid;
      req_last = vt[i].last;
      walmost_full = vt[i].af;
      wfull = vt[i].full;
      sample();
      chk("tbl_grant", 64'(grant), 64'(vt[i].grant));
      chk("tbl_ready", 64'(req_ready), 64'(vt[i].ready));
      chk("tbl_wr_en", 64'(wr_en), 64'(vt[i].wen));
      advance();
    end
    idle_reqs();
    walmost_full = 1'b0;
    wfull = 1'b0;
    // three-beat burst from req0
    wc = wr_count;
    left[0] = 3;
    repeat (6) begin
      drive(1'b0);
      tick();
    end
    chk("t1_writes", 64'(wr_count - wc), 64'(3));
    // full stalls a granted burst
    idle_reqs();
    wc = wr_count;
    left[1] = 6;
    repeat (3) begin
      drive(1'b0);
      tick();
    end
    wfull = 1'b1;
    repeat (4) begin
      drive(1'b0);
      tick();
    end
    chk("t3_stalled_writes", 64'(wr_count - wc), 64'(2));
    chk("t3_grant_held", 64'(grant), 64'(4'b0010));
    wfull = 1'b0;
    repeat (6) begin
      drive(1'b0);
      tick();
    end
    chk("t3_writes", 64'(wr_count - wc), 64'(6));
    // forced split at MAX_BURST with other requesters waiting
    idle_reqs();
    split_count = 0;
    src_log.delete();
    left[2] = 20;
    repeat (4) begin
      drive(1'b0);
      tick();
    end
    left[0] = 2;
    left[3] = 1;
    repeat (40) begin
      drive(1'b0);
      tick();
    end
    chk("t5_split_pulses", 64'(split_count), 64'(1));
    repeat (16) exp_src.push_back(2);
    exp_src.push_back(3);
    repeat (2) exp_src.push_back(0);
    repeat (4) exp_src.push_back(2);
    chk("t5_write_count", 64'(src_log.size()), 64'(exp_src.size()));
    for (int i = 0; i < exp_src.size() && i < src_log.size(); i++)
      chk($sformatf("t5_order_%0d", i), 64'(src_log[i]), 64'(exp_src[i]));
    // asynchronous reset in the middle of a burst
    idle_reqs();
    left[1] = 5;
    repeat (3) begin
      drive(1'b0);
      tick();
    end
    #2 reset_n = 1'b0;
    #1;
    chk("t6_grant", 64'(grant), 64'(0));
    chk("t6_wr_en", 64'(wr_en), 64'(0));
    chk("t6_ready", 64'(req_ready), 64'(0));
    model_reset();
    idle_reqs();
    tick();
    reset_n = 1'b1;
    left[0] = 1;
    left[1] = 1;
    left[3] = 1;
    drive(1'b0);
    tick();
    chk("t6_first_grant", 64'(grant), 64'(4'b0001));
    repeat (10) begin
      drive(1'b0);
      tick();
    end
    // randomized traffic with full / almost-full noise
    idle_reqs();
    repeat (3000) begin
      wfull = $urandom_range(4, 0) == 0;
      walmost_full = wfull || $urandom_range(3, 0) == 0;
      drive(1'b1);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
